// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock divider sequencer.
//   state_e      : sequencer state (IDLE / RUN / BURST)
//   MIN_DIV      : smallest divisor the counter supports (one high, one low)
//   DEFAULT_DIV  : divisor loaded at reset (20 MHz in -> 40 kHz out)
// ---------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV     = 2;
  localparam int unsigned DEFAULT_DIV = 500;

endpackage

// File: rtl/clk_div_core.sv
// ---------------------------------------------------------------------------
// clk_div_core
// Divide counter, wrap detect and clock_out compare.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   en         : generation enabled in the NEXT cycle
//   restart    : force the counter to 0 in the next cycle (start accepted)
//   div        : divisor in effect for the current period (>= 2)
//   wrap       : current cycle is the last of the period (cnt == div-1)
//   tick       : registered strobe, first cycle of every period
//   clock_out  : registered square wave, high while cnt < div/2
// ---------------------------------------------------------------------------
module clk_div_core #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] div,
  output logic             wrap,
  output logic             tick,
  output logic             clock_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;
  logic             clk_out_q;

  // The counter sits at 0 while idle and div is never below 2, so this
  // can only fire while generating.
  assign wrap = (cnt_q == (div - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || restart || wrap) begin
      cnt_d = '0;
    end
  end

  // Outputs are registered, so they are computed from the next count.
  // The divisor can only change where cnt_d == 0, and 0 < div/2 holds for
  // any legal divisor, so comparing against the current div is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= en && (cnt_d == '0);
      clk_out_q <= en && (cnt_d < (div >> 1));
    end
  end

  assign tick      = tick_q;
  assign clock_out = clk_out_q;

endmodule

// File: rtl/clk_div_sequencer.sv
// ---------------------------------------------------------------------------
// clk_div_sequencer
// Run/stop and reconfiguration controller for the programmable divider.
// Ports:
//   clock_in, reset       : clock and synchronous active-high reset
//   cfg_valid/cfg_div     : divisor offer; cfg_ready = no divisor pending
//   start, burst_len      : begin generation (burst_len 0 = continuous)
//   stop                  : end generation at the end of the current period
//   clock_out, tick       : divided clock and period-start strobe
//   done                  : one-cycle strobe on every return to IDLE
//   busy                  : not IDLE
//   period_cnt            : completed periods since the last start
//   dbg_state             : current sequencer state
// Handshake: a divisor transfers on a cycle where cfg_valid && cfg_ready;
// cfg_valid may be raised at any time, cfg_ready is combinational and
// drops while a divisor waits for the next period boundary.
// ---------------------------------------------------------------------------
module clk_div_sequencer #(
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned BURST_W     = 16,
  parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_div,
  output logic               cfg_ready,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               stop,
  output logic               clock_out,
  output logic               tick,
  output logic               done,
  output logic               busy,
  output logic [BURST_W-1:0] period_cnt,
  output logic [1:0]         dbg_state
);
  import clk_div_pkg::*;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   active_div_q, active_div_d;
  logic [CNT_W-1:0]   pend_div_q, pend_div_d;
  logic               pend_valid_q, pend_valid_d;
  logic               stop_req_q, stop_req_d;
  logic [BURST_W-1:0] burst_len_q, burst_len_d;
  logic [BURST_W-1:0] period_cnt_q, period_cnt_d;
  logic               done_q, busy_q;

  logic               core_wrap;
  logic               running, at_wrap, last_period;
  logic               xfer, start_acc;
  logic [CNT_W-1:0]   div_clamped;

  assign cfg_ready   = !pend_valid_q;
  assign xfer        = cfg_valid && cfg_ready;
  assign div_clamped = (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;

  // stop has priority over start in IDLE
  assign start_acc   = (state_q == IDLE) && start && !stop;
  assign running     = (state_q != IDLE);
  assign at_wrap     = running && core_wrap;

  // A stop arriving in the wrap cycle itself already ends this period.
  assign last_period = at_wrap &&
                       (stop_req_q || stop ||
                        ((state_q == BURST) &&
                         ((period_cnt_q + BURST_W'(1)) == burst_len_q)));

  always_comb begin
    state_d      = state_q;
    active_div_d = active_div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    burst_len_d  = burst_len_q;
    period_cnt_d = period_cnt_q;

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d      = (burst_len == '0) ? RUN : BURST;
          burst_len_d  = burst_len;
          period_cnt_d = '0;
        end
      end
      RUN, BURST: begin
        if (last_period) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Divisor updates land only where the counter restarts from 0.
    if (!running) begin
      if (xfer) begin
        active_div_d = div_clamped;
      end
    end else if (at_wrap) begin
      if (xfer) begin
        active_div_d = div_clamped;
      end else if (pend_valid_q) begin
        active_div_d = pend_div_q;
        pend_valid_d = 1'b0;
      end
    end else if (xfer) begin
      pend_div_d   = div_clamped;
      pend_valid_d = 1'b1;
    end

    // Saturates rather than wraps during long continuous runs.
    if (at_wrap && (period_cnt_q != '1)) begin
      period_cnt_d = period_cnt_q + BURST_W'(1);
    end

    stop_req_d = stop_req_q || (running && stop);
    if (state_d == IDLE) begin
      stop_req_d = 1'b0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q      <= IDLE;
      active_div_q <= CNT_W'(DEFAULT_DIV);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      stop_req_q   <= 1'b0;
      burst_len_q  <= '0;
      period_cnt_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_div_q <= active_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      stop_req_q   <= stop_req_d;
      burst_len_q  <= burst_len_d;
      period_cnt_q <= period_cnt_d;
      done_q       <= running && (state_d == IDLE);
      busy_q       <= (state_d != IDLE);
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk       (clock_in),
    .rst       (reset),
    .en        (state_d != IDLE),
    .restart   (start_acc),
    .div       (active_div_q),
    .wrap      (core_wrap),
    .tick      (tick),
    .clock_out (clock_out)
  );

  assign done       = done_q;
  assign busy       = busy_q;
  assign period_cnt = period_cnt_q;
  assign dbg_state  = state_q;

endmodule
